// File: rtl/alu_uart_bridge.sv
// Command front-end for the board ALU: collects operand A, operand B and an opcode
// from the UART receiver, then sends the registered ALU result back through the transmitter.
module alu_uart_bridge #(
    parameter int NB_DATA        = 8,
    parameter int NB_OPCODE      = 6,
    parameter int NB_TIMEOUT     = 24,
    parameter int TIMEOUT_CYCLES = 10000000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done,
    output logic [NB_DATA-1:0]   o_alu_op_1,
    output logic [NB_DATA-1:0]   o_alu_op_2,
    output logic [NB_OPCODE-1:0] o_alu_opcode,
    input  logic [NB_DATA-1:0]   i_alu_result,
    output logic [NB_DATA-1:0]   o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_done,
    output logic                 o_error,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
    localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
    localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
    localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
    localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
    localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
    localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);
    localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);

    state_t                state;
    logic [NB_TIMEOUT-1:0] count;
    logic [NB_OPCODE-1:0]  rx_code;
    logic                  code_valid;

    assign o_state = state;
    assign rx_code = i_rx_data[NB_OPCODE-1:0];

    always_comb begin
        code_valid = 1'b0;
        case (rx_code)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: code_valid = 1'b1;
            default:                        code_valid = 1'b0;
        endcase
    end

    // o_error and o_tx_start default low each cycle, so every assertion is a single-cycle pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= WAIT_A;
            count        <= '0;
            o_alu_op_1   <= '0;
            o_alu_op_2   <= '0;
            o_alu_opcode <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            o_error    <= 1'b0;
            o_tx_start <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_alu_op_1 <= i_rx_data;
                        count      <= '0;
                        state      <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    // An arriving byte beats an expiring timeout in the same cycle.
                    if (i_rx_done) begin
                        o_alu_op_2 <= i_rx_data;
                        count      <= '0;
                        state      <= WAIT_OP;
                    end else if (count == TIMEOUT_LAST) begin
                        o_error <= 1'b1;
                        count   <= '0;
                        state   <= WAIT_A;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        count <= '0;
                        if (code_valid) begin
                            o_alu_opcode <= rx_code;
                            state        <= EXEC;
                        end else begin
                            o_error <= 1'b1;
                            state   <= WAIT_A;
                        end
                    end else if (count == TIMEOUT_LAST) begin
                        o_error <= 1'b1;
                        count   <= '0;
                        state   <= WAIT_A;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                EXEC: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    state      <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) begin
                        state <= WAIT_A;
                    end
                end
                default: begin
                    state <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_bridge.sv
// Bench for alu_uart_bridge: behavioural ALU stand-in, directed command scenarios and
// randomized command streams checked against an arithmetic reference model.
module tb_alu_uart_bridge;

    localparam int NB_DATA   = 8;
    localparam int NB_OPCODE = 6;
    localparam int T_CYCLES  = 16;

    localparam logic [2:0] S_WAIT_A  = 3'd0;
    localparam logic [2:0] S_WAIT_B  = 3'd1;
    localparam logic [2:0] S_WAIT_OP = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WAIT_TX = 3'd4;

    logic                 clk;
    logic                 rst;
    logic [NB_DATA-1:0]   rx_data;
    logic                 rx_done;
    logic [NB_DATA-1:0]   alu_op_1;
    logic [NB_DATA-1:0]   alu_op_2;
    logic [NB_OPCODE-1:0] alu_opcode;
    logic [NB_DATA-1:0]   alu_result;
    logic [NB_DATA-1:0]   tx_data;
    logic                 tx_start;
    logic                 tx_done;
    logic                 error;
    logic [2:0]           state;

    int checks   = 0;
    int failures = 0;
    int err_seen = 0;
    int err_exp  = 0;
    logic [NB_DATA-1:0]   exp_q[$];
    logic [NB_DATA-1:0]   exp_op1;
    logic [NB_DATA-1:0]   exp_op2;
    logic [NB_OPCODE-1:0] exp_opc;

    int valid_codes[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

    alu_uart_bridge #(
        .NB_DATA(NB_DATA), .NB_OPCODE(NB_OPCODE), .NB_TIMEOUT(24), .TIMEOUT_CYCLES(T_CYCLES)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_alu_op_1(alu_op_1), .o_alu_op_2(alu_op_2), .o_alu_opcode(alu_opcode),
        .i_alu_result(alu_result), .o_tx_data(tx_data), .o_tx_start(tx_start),
        .i_tx_done(tx_done), .o_error(error), .o_state(state)
    );

    // Board ALU stand-in; both shifts act on the signed operand, as on the board.
    always_comb begin
        alu_result = '0;
        case (alu_opcode)
            6'h20: alu_result = alu_op_1 + alu_op_2;
            6'h22: alu_result = alu_op_1 - alu_op_2;
            6'h24: alu_result = alu_op_1 & alu_op_2;
            6'h25: alu_result = alu_op_1 | alu_op_2;
            6'h26: alu_result = alu_op_1 ^ alu_op_2;
            6'h27: alu_result = ~(alu_op_1 | alu_op_2);
            6'h03, 6'h02: alu_result = 8'($signed(alu_op_1) >>> alu_op_2);
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_valid(input logic [7:0] b);
        for (int i = 0; i < 8; i++)
            if (int'(b[5:0]) == valid_codes[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Integer-arithmetic reference of the ALU operations.
    function automatic logic [7:0] ref_alu(input logic [5:0] op, input int a, input int b);
        int v;
        int r;
        r = 0;
        case (op)
            6'h20: r = a + b;
            6'h22: r = a - b + 256;
            6'h24: for (int i = 0; i < 8; i++) if (((a >> i) & 1) && ((b >> i) & 1)) r += (1 << i);
            6'h25: for (int i = 0; i < 8; i++) if (((a >> i) & 1) || ((b >> i) & 1)) r += (1 << i);
            6'h26: for (int i = 0; i < 8; i++) if (((a >> i) & 1) != ((b >> i) & 1)) r += (1 << i);
            6'h27: for (int i = 0; i < 8; i++) if (!((a >> i) & 1) && !((b >> i) & 1)) r += (1 << i);
            6'h03, 6'h02: begin
                v = (a >= 128) ? a - 256 : a;
                for (int i = 0; i < b; i++) v = (v < 0) ? -((-v + 1) / 2) : v / 2;
                r = v + 256;
            end
            default: r = 0;
        endcase
        return 8'(r % 256);
    endfunction

    always @(negedge clk) begin
        if (error) err_seen++;
        if (tx_start) begin
            check("start_no_error", 32'(error), 0);
            check("start_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = $urandom_range(0, 255);
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_op1 = '0; exp_op2 = '0; exp_opc = '0;
        check("rst_state", 32'(state), 32'(S_WAIT_A));
        check("rst_outputs", {alu_op_1, alu_op_2, 2'b00, alu_opcode, tx_data}, 0);
        check("rst_pulses", {tx_start, error}, 0);
    endtask

    // Sends a full command; for valid opcodes finishes the transmit handshake too.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input int gap, input int tx_delay);
        logic [7:0] exp_res;
        send_byte(a);
        exp_op1 = a;
        check("op1", 32'(alu_op_1), 32'(exp_op1));
        idle(gap);
        send_byte(b);
        exp_op2 = b;
        check("op2", 32'(alu_op_2), 32'(exp_op2));
        idle(gap);
        send_byte(opb);
        if (is_valid(opb)) begin
            exp_opc = opb[5:0];
            exp_res = ref_alu(exp_opc, int'(a), int'(b));
            exp_q.push_back(exp_res);
            check("opcode", 32'(alu_opcode), 32'(exp_opc));
            check("exec_state", 32'(state), 32'(S_EXEC));
            check("start_early", 32'(tx_start), 0);
            @(negedge clk);
            check("start_latency", 32'(tx_start), 1);
            check("result", 32'(tx_data), 32'(exp_res));
            @(negedge clk);
            check("start_one_cycle", 32'(tx_start), 0);
            idle(tx_delay);
            check("tx_hold", 32'(tx_data), 32'(exp_res));
            check("wait_tx_state", 32'(state), 32'(S_WAIT_TX));
            pulse_tx_done();
            check("done_state", 32'(state), 32'(S_WAIT_A));
        end else begin
            err_exp++;
            check("bad_op_error", 32'(error), 1);
            check("bad_op_state", 32'(state), 32'(S_WAIT_A));
            check("bad_op_keep", 32'(alu_opcode), 32'(exp_opc));
            @(negedge clk);
            check("bad_op_pulse", 32'(error), 0);
        end
    endtask

    initial begin
        logic [7:0] a, b, opb;
        rst = 1'b1; rx_data = '0; rx_done = 1'b0; tx_done = 1'b0;
        exp_op1 = '0; exp_op2 = '0; exp_opc = '0;
        idle(2);
        do_reset();

        // Directed command scenarios
        run_cmd(8'h05, 8'h03, 8'h20, 0, 0);
        run_cmd(8'h03, 8'h05, 8'h22, 0, 2);
        run_cmd(8'h80, 8'h02, 8'h03, 1, 0);
        run_cmd(8'h80, 8'h02, 8'h02, 0, 3);
        run_cmd(8'h01, 8'h02, 8'h11, 0, 0);
        run_cmd(8'h0F, 8'hF0, 8'h25, 0, 1);

        // No timeout while idle in WAIT_A
        idle(3 * T_CYCLES);
        check("idle_no_error", 32'(err_seen), 32'(err_exp));

        // Timeout in WAIT_B
        send_byte(8'hAA);
        idle(T_CYCLES - 1);
        check("tmo_b_early", {29'd0, state}, 32'(S_WAIT_B));
        check("tmo_b_no_err", 32'(error), 0);
        @(negedge clk);
        err_exp++;
        check("tmo_b_error", 32'(error), 1);
        check("tmo_b_state", 32'(state), 32'(S_WAIT_A));
        @(negedge clk);
        check("tmo_b_pulse", 32'(error), 0);
        run_cmd(8'h02, 8'h03, 8'h24, 0, 0);

        // Timeout in WAIT_OP
        send_byte(8'h11);
        send_byte(8'h22);
        exp_op1 = 8'h11; exp_op2 = 8'h22;
        idle(T_CYCLES);
        err_exp++;
        check("tmo_op_error", 32'(error), 1);
        check("tmo_op_state", 32'(state), 32'(S_WAIT_A));

        // Bytes arriving on the last allowed cycle win over the timeout
        send_byte(8'h07);
        idle(T_CYCLES - 1);
        send_byte(8'h09);
        check("late_b_state", 32'(state), 32'(S_WAIT_OP));
        check("late_b_no_err", 32'(error), 0);
        idle(T_CYCLES - 1);
        exp_q.push_back(ref_alu(6'h26, 7, 9));
        exp_opc = 6'h26;
        send_byte(8'hE6);
        check("late_op_state", 32'(state), 32'(S_EXEC));
        check("late_op_no_err", 32'(error), 0);
        idle(2);

        // Bytes during WAIT_TX are dropped
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
        check("drop_state", 32'(state), 32'(S_WAIT_TX));
        check("drop_hold", 32'(tx_data), 32'(ref_alu(6'h26, 7, 9)));
        check("drop_op1", 32'(alu_op_1), 32'h07);
        pulse_tx_done();
        check("drop_done_state", 32'(state), 32'(S_WAIT_A));
        run_cmd(8'h33, 8'h0F, 8'h24, 0, 0);

        // tx_done outside WAIT_TX is ignored
        pulse_tx_done();
        check("stray_done_state", 32'(state), 32'(S_WAIT_A));

        // Reset in WAIT_OP
        send_byte(8'h44);
        send_byte(8'h55);
        check("pre_rst_op", 32'(state), 32'(S_WAIT_OP));
        do_reset();
        pulse_tx_done();
        check("post_rst_done", 32'(state), 32'(S_WAIT_A));
        run_cmd(8'h09, 8'h04, 8'h22, 0, 0);

        // Reset in WAIT_TX
        exp_q.push_back(ref_alu(6'h27, 8'h12, 8'h21));
        send_byte(8'h12);
        send_byte(8'h21);
        send_byte(8'h27);
        idle(2);
        check("pre_rst_tx", 32'(state), 32'(S_WAIT_TX));
        do_reset();
        pulse_tx_done();
        check("post_rst_tx_done", 32'(state), 32'(S_WAIT_A));
        run_cmd(8'hC8, 8'h64, 8'h20, 0, 0);

        // Randomized command stream
        for (int n = 0; n < 60; n++) begin
            a = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) opb = 8'($urandom_range(0, 255));
            else opb = {2'($urandom_range(0, 3)), 6'(valid_codes[$urandom_range(0, 7)])};
            run_cmd(a, b, opb, $urandom_range(0, T_CYCLES - 2), $urandom_range(0, 12));
            idle($urandom_range(0, 4));
        end

        idle(4);
        check("error_count", 32'(err_seen), 32'(err_exp));
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_uart_bridge.md
Name: alu_uart_bridge

Overview:
- Command front-end for the 8-bit ALU on the Basys3 board.
- Consumes a byte stream from the UART receiver: operand A, operand B, then opcode.
- Drives the ALU operand and opcode inputs, registers the combinational ALU result, and hands it to the UART transmitter as one byte.
- Sits between uart_rx / uart_tx and the alu instance in the top level.

Parameters:
- NB_DATA, 8, width of operands, result and UART bytes
- NB_OPCODE, 6, width of ALU opcode
- NB_TIMEOUT, 24, width of the inter-byte timeout counter
- TIMEOUT_CYCLES, 10000000, idle clocks allowed between bytes of one command (100 ms at 100 MHz)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous reset, active-high
- i_rx_data  in  NB_DATA  received byte; valid only when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse from uart_rx, byte available
- o_alu_op_1  out  NB_DATA  operand A to ALU
- o_alu_op_2  out  NB_DATA  operand B to ALU
- o_alu_opcode  out  NB_OPCODE  opcode to ALU
- i_alu_result  in  NB_DATA  combinational ALU result
- o_tx_data  out  NB_DATA  byte for uart_tx; held stable while state is WAIT_TX
- o_tx_start  out  1  one-cycle pulse, start transmission
- i_tx_done  in  1  one-cycle pulse from uart_tx, byte sent
- o_error  out  1  one-cycle pulse: invalid opcode or timeout

Behaviour:
- Reset (i_reset sampled high on an i_clk edge): state=WAIT_A; all outputs 0; timeout counter 0. Reset has priority over every other event in any state.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- WAIT_A:
  - On i_rx_done, o_alu_op_1<=i_rx_data and go to WAIT_B.
  - No timeout in this state.
- WAIT_B:
  - On i_rx_done, o_alu_op_2<=i_rx_data, counter cleared, go to WAIT_OP.
- WAIT_OP:
  - On i_rx_done, check i_rx_data[NB_OPCODE-1:0]; upper bits are ignored.
  - Valid codes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
  - Valid code: o_alu_opcode<=code, go to EXEC.
  - Invalid code: o_alu_opcode unchanged, o_error pulses 1 cycle, go to WAIT_A.
- Timeout (WAIT_B and WAIT_OP only):
  - Counter increments every cycle without i_rx_done and clears on entry to each state.
  - When it reaches TIMEOUT_CYCLES-1 without a byte: o_error pulses, go to WAIT_A.
  - A byte arriving in that same cycle wins; no error.
- EXEC (one cycle; ALU inputs are stable):
  - o_tx_data<=i_alu_result.
  - o_tx_start is 1 during the following cycle only.
  - Go to WAIT_TX.
- WAIT_TX:
  - Hold o_tx_data.
  - On i_tx_done, go to WAIT_A.
  - No timeout; waits indefinitely.
- Latency: opcode byte pulse in cycle N -> EXEC in N+1 -> o_tx_start=1 in N+2.
- i_rx_done in EXEC or WAIT_TX: byte dropped silently, no error.
- i_tx_done outside WAIT_TX: ignored.
- Operand and opcode registers hold their values until overwritten. The ALU output therefore stays valid for board LEDs between commands.
- o_error and o_tx_start are never high in the same cycle.
- Arithmetic is entirely in the ALU; this block does no width extension. The result is a truncated NB_DATA byte and carry is not reported.

Test Plan:
- Bytes 0x05, 0x03, 0x20 -> o_alu_op_1=0x05, o_alu_op_2=0x03, o_alu_opcode=0x20; o_tx_start pulses exactly 2 cycles after the third i_rx_done with o_tx_data=0x08; after i_tx_done, state=WAIT_A.
- Bytes 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE; then 0x80, 0x02, 0x03 (SRA) -> 0xE0; then 0x80, 0x02, 0x02 (SRL) -> 0xE0 because the ALU operand is signed; the bench compares against the reference model for each opcode.
- Bytes 0x01, 0x02, 0x11 -> one-cycle o_error, no o_tx_start, o_alu_opcode keeps its previous value; the next 0x0F, 0xF0, 0x25 -> o_tx_data=0xFF.
- With TIMEOUT_CYCLES=16: send 0xAA only and wait 16 cycles -> o_error pulses once, state=WAIT_A; then 0x02, 0x03, 0x24 -> o_tx_data=0x02; a byte at cycle 15 of the wait -> no error.
- During WAIT_TX, inject 3 extra i_rx_done bytes -> all dropped, no new o_tx_start; after i_tx_done a fresh 3-byte command works normally.
- Assert i_reset in WAIT_OP and again in WAIT_TX -> next cycle all outputs 0 and state=WAIT_A; a later i_tx_done has no effect; a following command completes correctly.
